// File: rtl/vlsu_simd_gather.sv
// Purpose: joins NrSimd ELEN-wide load-result slices into one wide result.
//   Each slice owns a small FIFO. The wide result is presented only when
//   every slice FIFO holds at least one entry.
// Latency: 1 cycle from a slice push to visibility at the FIFO head.
//   Sustained throughput is one wide result per cycle.
// Backpressure: slc_gnt_o[i] is !full[i] and comes straight from a register.
//   Results are held stable while res_req_o=1 and res_gnt_i=0.
// Ports:
//   clk_i, rst_ni                       clock, async active-low reset
//   slc_req_i/addr/id/wdata/be, slc_gnt_o  per-slice push interface
//   res_req_o/addr/id/wdata/be, res_gnt_i  wide result interface
//   mismatch_o                          sticky addr/id mismatch flag
// Option: define VLSU_SIMD_GATHER_MISMATCH_CHECK_EN to enable the addr/id
//   mismatch check. Without it, mismatch_o is tied to 0.
module vlsu_simd_gather #(
  parameter int unsigned NrSimd    = 2,
  parameter int unsigned ElemWidth = 64,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned IdWidth   = 3,
  parameter int unsigned Depth     = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NrSimd-1:0]             slc_req_i,
  input  logic [NrSimd*AddrWidth-1:0]   slc_addr_i,
  input  logic [NrSimd*IdWidth-1:0]     slc_id_i,
  input  logic [NrSimd*ElemWidth-1:0]   slc_wdata_i,
  input  logic [NrSimd*ElemWidth/8-1:0] slc_be_i,
  output logic [NrSimd-1:0]             slc_gnt_o,
  output logic                          res_req_o,
  output logic [AddrWidth-1:0]          res_addr_o,
  output logic [IdWidth-1:0]            res_id_o,
  output logic [NrSimd*ElemWidth-1:0]   res_wdata_o,
  output logic [NrSimd*ElemWidth/8-1:0] res_be_o,
  input  logic                          res_gnt_i,
  output logic                          mismatch_o
);

  localparam int unsigned BeWidth = ElemWidth / 8;
  localparam int unsigned PtrW    = $clog2(Depth);
  localparam int unsigned CntW    = PtrW + 1;

  logic [NrSimd-1:0]                w_push;
  logic [NrSimd-1:0]                w_empty;
  logic                             w_pop;
  logic [NrSimd-1:0][AddrWidth-1:0] w_head_addr;
  logic [NrSimd-1:0][IdWidth-1:0]   w_head_id;

  // A pop needs every slice non-empty. Any res_gnt_i without res_req_o
  // is therefore ignored.
  assign res_req_o  = &(~w_empty);
  assign w_pop      = res_req_o & res_gnt_i;
  assign res_addr_o = w_head_addr[0];
  assign res_id_o   = w_head_id[0];

  for (genvar g = 0; g < NrSimd; g++) begin : g_slice
    logic [AddrWidth-1:0] r_addr  [Depth];
    logic [IdWidth-1:0]   r_id    [Depth];
    logic [ElemWidth-1:0] r_wdata [Depth];
    logic [BeWidth-1:0]   r_be    [Depth];
    logic [PtrW-1:0]      r_wptr;
    logic [PtrW-1:0]      r_rptr;
    logic [CntW-1:0]      r_cnt;
    logic                 r_gnt;
    logic [CntW-1:0]      w_cnt_nxt;

    assign w_push[g]  = slc_req_i[g] & r_gnt;
    assign w_empty[g] = (r_cnt == '0);
    assign slc_gnt_o[g] = r_gnt;

    always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_push[g] && !w_pop) begin
        w_cnt_nxt = r_cnt + 1'b1;
      end else if (!w_push[g] && w_pop) begin
        w_cnt_nxt = r_cnt - 1'b1;
      end
    end

    // The grant is registered from the next occupancy. A slot freed by a
    // pop is therefore offered one cycle later, never in the same cycle.
    // Storage is cleared on reset so that the result outputs read 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
        r_gnt  <= 1'b1;
        for (int d = 0; d < Depth; d++) begin
          r_addr[d]  <= '0;
          r_id[d]    <= '0;
          r_wdata[d] <= '0;
          r_be[d]    <= '0;
        end
      end else begin
        r_cnt <= w_cnt_nxt;
        r_gnt <= (w_cnt_nxt != CntW'(Depth));
        if (w_push[g]) begin
          r_addr[r_wptr]  <= slc_addr_i[g*AddrWidth +: AddrWidth];
          r_id[r_wptr]    <= slc_id_i[g*IdWidth +: IdWidth];
          r_wdata[r_wptr] <= slc_wdata_i[g*ElemWidth +: ElemWidth];
          r_be[r_wptr]    <= slc_be_i[g*BeWidth +: BeWidth];
          r_wptr          <= r_wptr + 1'b1;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + 1'b1;
        end
      end
    end

    assign w_head_addr[g]                        = r_addr[r_rptr];
    assign w_head_id[g]                          = r_id[r_rptr];
    assign res_wdata_o[g*ElemWidth +: ElemWidth] = r_wdata[r_rptr];
    assign res_be_o[g*BeWidth +: BeWidth]        = r_be[r_rptr];
  end

`ifdef VLSU_SIMD_GATHER_MISMATCH_CHECK_EN
  logic w_any_diff;
  logic r_mismatch;

  always_comb begin
    w_any_diff = 1'b0;
    for (int i = 1; i < NrSimd; i++) begin
      if ((w_head_addr[i] != w_head_addr[0]) || (w_head_id[i] != w_head_id[0])) begin
        w_any_diff = 1'b1;
      end
    end
  end

  // The flag is sticky until reset. Heads are compared only on a real pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mismatch <= 1'b0;
    end else if (w_pop && w_any_diff) begin
      r_mismatch <= 1'b1;
    end
  end

  assign mismatch_o = r_mismatch;
`else
  // Heads of slices other than slice 0 only feed the mismatch check.
  logic w_unused_heads;
  assign w_unused_heads = ^{w_head_addr, w_head_id};
  assign mismatch_o     = 1'b0;
`endif

endmodule

// File: tb/tb_vlsu_simd_gather.sv
module tb_vlsu_simd_gather;

  logic         clk_i;
  logic         rst_ni;
  logic [1:0]   slc_req_i;
  logic [63:0]  slc_addr_i;
  logic [5:0]   slc_id_i;
  logic [127:0] slc_wdata_i;
  logic [15:0]  slc_be_i;
  logic [1:0]   slc_gnt_o;
  logic         res_req_o;
  logic [31:0]  res_addr_o;
  logic [2:0]   res_id_o;
  logic [127:0] res_wdata_o;
  logic [15:0]  res_be_o;
  logic         res_gnt_i;
  logic         mismatch_o;

  vlsu_simd_gather dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .slc_req_i   (slc_req_i),
    .slc_addr_i  (slc_addr_i),
    .slc_id_i    (slc_id_i),
    .slc_wdata_i (slc_wdata_i),
    .slc_be_i    (slc_be_i),
    .slc_gnt_o   (slc_gnt_o),
    .res_req_o   (res_req_o),
    .res_addr_o  (res_addr_o),
    .res_id_o    (res_id_o),
    .res_wdata_o (res_wdata_o),
    .res_be_o    (res_be_o),
    .res_gnt_i   (res_gnt_i),
    .mismatch_o  (mismatch_o)
  );

  typedef struct {
    logic [31:0]  addr;
    logic [2:0]   id;
    logic [127:0] wdata;
    logic [15:0]  be;
  } exp_t;

  exp_t sb[$];
  int   errs   = 0;
  int   checks = 0;
  int   pops   = 0;

`ifdef VLSU_SIMD_GATHER_MISMATCH_CHECK_EN
  localparam logic EXP_MISMATCH = 1'b1;
`else
  localparam logic EXP_MISMATCH = 1'b0;
`endif

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drv(input int s, input logic [31:0] a, input logic [2:0] id,
                     input logic [63:0] d, input logic [7:0] be);
    slc_req_i[s]          = 1'b1;
    slc_addr_i[s*32 +: 32] = a;
    slc_id_i[s*3 +: 3]     = id;
    slc_wdata_i[s*64 +: 64] = d;
    slc_be_i[s*8 +: 8]     = be;
  endtask

  task automatic idle(input int s);
    slc_req_i[s] = 1'b0;
  endtask

  task automatic expect_res(input logic [31:0] a, input logic [2:0] id,
                            input logic [127:0] w, input logic [15:0] be);
    exp_t e;
    e.addr = a; e.id = id; e.wdata = w; e.be = be;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every accepted wide result must match the oldest
  // expected entry.
  always @(negedge clk_i) begin
    if (rst_ni && res_req_o && res_gnt_i) begin
      pops++;
      if (sb.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_result: got addr=%0h wdata=%0h expected none", res_addr_o, res_wdata_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_addr", 128'(res_addr_o), 128'(e.addr));
        chk("res_id", 128'(res_id_o), 128'(e.id));
        chk("res_wdata", res_wdata_o, e.wdata);
        chk("res_be", 128'(res_be_o), 128'(e.be));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] held;
    int p0;
    int lowcnt;
    rst_ni = 1'b0; res_gnt_i = 1'b0;
    slc_req_i = '0; slc_addr_i = '0; slc_id_i = '0; slc_wdata_i = '0; slc_be_i = '0;
    tick();
    // Values during reset
    chk("rst_req", 128'(res_req_o), 128'(0));
    chk("rst_gnt", 128'(slc_gnt_o), 128'(2'b11));
    chk("rst_mismatch", 128'(mismatch_o), 128'(0));
    chk("rst_addr", 128'(res_addr_o), 128'(0));
    chk("rst_id", 128'(res_id_o), 128'(0));
    chk("rst_wdata", res_wdata_o, 128'(0));
    chk("rst_be", 128'(res_be_o), 128'(0));
    tick();
    rst_ni = 1'b1;
    tick();

    // Slices pushed at different times; the result appears one cycle after the later push.
    drv(0, 32'h10, 3'd1, {8{8'hAA}}, 8'hFF);
    expect_res(32'h10, 3'd1, {{8{8'hBB}}, {8{8'hAA}}}, 16'h0FFF);
    tick();
    idle(0);
    chk("join_req_c1", 128'(res_req_o), 128'(0));
    tick(); tick();
    chk("join_req_c3", 128'(res_req_o), 128'(0));
    drv(1, 32'h10, 3'd1, {8{8'hBB}}, 8'h0F);
    tick();
    idle(1);
    chk("join_req_c4", 128'(res_req_o), 128'(1));
    chk("join_wdata_c4", res_wdata_o, {{8{8'hBB}}, {8{8'hAA}}});
    held = res_wdata_o;
    tick();
    chk("stable_req", 128'(res_req_o), 128'(1));
    chk("stable_wdata", res_wdata_o, held);
    res_gnt_i = 1'b1;
    tick();
    res_gnt_i = 1'b0;
    chk("join_drained", 128'(res_req_o), 128'(0));

    // Full FIFO: the grant falls after two pushes and returns the cycle after a pop.
    drv(0, 32'h20, 3'd2, {8{8'h01}}, 8'h11);
    drv(1, 32'h20, 3'd2, {8{8'h11}}, 8'h22);
    expect_res(32'h20, 3'd2, {{8{8'h11}}, {8{8'h01}}}, 16'h2211);
    tick();
    drv(0, 32'h24, 3'd3, {8{8'h02}}, 8'h33);
    drv(1, 32'h24, 3'd3, {8{8'h12}}, 8'h44);
    expect_res(32'h24, 3'd3, {{8{8'h12}}, {8{8'h02}}}, 16'h4433);
    tick();
    chk("full_gnt", 128'(slc_gnt_o), 128'(2'b00));
    drv(0, 32'h28, 3'd4, {8{8'h03}}, 8'h55);
    idle(1);
    tick();
    chk("full_hold_gnt", 128'(slc_gnt_o), 128'(2'b00));
    res_gnt_i = 1'b1;
    tick();
    res_gnt_i = 1'b0;
    chk("gnt_after_pop", 128'(slc_gnt_o), 128'(2'b11));
    tick();
    idle(0);
    drv(1, 32'h28, 3'd4, {8{8'h13}}, 8'h66);
    expect_res(32'h28, 3'd4, {{8{8'h13}}, {8{8'h03}}}, 16'h6655);
    tick();
    idle(1);
    chk("refill_gnt", 128'(slc_gnt_o), 128'(2'b00));
    res_gnt_i = 1'b1;
    tick(); tick();
    res_gnt_i = 1'b0;
    chk("full_drained", 128'(res_req_o), 128'(0));

    // Streaming 16 beats with res_gnt_i held high.
    res_gnt_i = 1'b1;
    p0 = pops;
    lowcnt = 0;
    for (int k = 0; k < 16; k++) begin
      logic [63:0] d0;
      logic [63:0] d1;
      d0 = 64'hA0A0_0000_0000_0000 | 64'(k);
      d1 = 64'hB0B0_0000_0000_0000 | 64'(k * 3);
      drv(0, 32'h100 + 32'(4 * k), 3'(k), d0, 8'(k));
      drv(1, 32'h100 + 32'(4 * k), 3'(k), d1, 8'(255 - k));
      expect_res(32'h100 + 32'(4 * k), 3'(k), {d1, d0}, {8'(255 - k), 8'(k)});
      if (slc_gnt_o != 2'b11) lowcnt++;
      tick();
    end
    idle(0); idle(1);
    tick();
    chk("stream_pops", 128'(pops - p0), 128'(16));
    chk("stream_gnt_low_cycles", 128'(lowcnt), 128'(0));
    res_gnt_i = 1'b0;

    // A grant on empty FIFOs is ignored.
    res_gnt_i = 1'b1;
    p0 = pops;
    tick(); tick(); tick();
    chk("empty_gnt_req", 128'(res_req_o), 128'(0));
    chk("empty_gnt_slc", 128'(slc_gnt_o), 128'(2'b11));
    chk("empty_gnt_pops", 128'(pops - p0), 128'(0));
    res_gnt_i = 1'b0;
    drv(0, 32'h40, 3'd5, 64'h0123_4567_89AB_CDEF, 8'hC3);
    drv(1, 32'h40, 3'd5, 64'hFEDC_BA98_7654_3210, 8'h3C);
    expect_res(32'h40, 3'd5, {64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF}, 16'h3CC3);
    tick();
    idle(0); idle(1);
    chk("after_empty_req", 128'(res_req_o), 128'(1));
    res_gnt_i = 1'b1;
    tick();
    res_gnt_i = 1'b0;
    chk("pre_mismatch", 128'(mismatch_o), 128'(0));

    // Heads differing in id on a pop.
    drv(0, 32'h50, 3'd1, {8{8'h5A}}, 8'hFF);
    drv(1, 32'h50, 3'd2, {8{8'hA5}}, 8'hFF);
    expect_res(32'h50, 3'd1, {{8{8'hA5}}, {8{8'h5A}}}, 16'hFFFF);
    tick();
    idle(0); idle(1);
    chk("mm_before_pop", 128'(mismatch_o), 128'(0));
    res_gnt_i = 1'b1;
    tick();
    res_gnt_i = 1'b0;
    chk("mm_next_cycle", 128'(mismatch_o), 128'(EXP_MISMATCH));
    tick(); tick();
    chk("mm_sticky", 128'(mismatch_o), 128'(EXP_MISMATCH));

    // Reset with two entries queued in each slice discards them.
    drv(0, 32'h60, 3'd6, {8{8'h66}}, 8'hFF);
    drv(1, 32'h60, 3'd6, {8{8'h77}}, 8'hFF);
    tick();
    drv(0, 32'h64, 3'd7, {8{8'h68}}, 8'hFF);
    drv(1, 32'h64, 3'd7, {8{8'h78}}, 8'hFF);
    tick();
    idle(0); idle(1);
    chk("prerst_req", 128'(res_req_o), 128'(1));
    rst_ni = 1'b0;
    #1;
    chk("midrst_req", 128'(res_req_o), 128'(0));
    chk("midrst_gnt", 128'(slc_gnt_o), 128'(2'b11));
    chk("midrst_mismatch", 128'(mismatch_o), 128'(0));
    chk("midrst_wdata", res_wdata_o, 128'(0));
    tick();
    rst_ni = 1'b1;
    res_gnt_i = 1'b1;
    p0 = pops;
    tick(); tick(); tick();
    chk("postrst_req", 128'(res_req_o), 128'(0));
    chk("postrst_pops", 128'(pops - p0), 128'(0));
    res_gnt_i = 1'b0;
    drv(0, 32'h70, 3'd2, {8{8'h9C}}, 8'h0F);
    drv(1, 32'h70, 3'd2, {8{8'hC9}}, 8'hF0);
    expect_res(32'h70, 3'd2, {{8{8'hC9}}, {8{8'h9C}}}, 16'hF00F);
    tick();
    idle(0); idle(1);
    res_gnt_i = 1'b1;
    tick();
    res_gnt_i = 1'b0;
    tick();

    chk("scoreboard_left", 128'(sb.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
